// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: accepts one row of operands per beat and presents it to
// the PE array edge as a diagonal wavefront, lane i delayed by i+1 cycles.
// A small IDLE/FEED/DRAIN controller sequences a job and flags its completion.
module operand_skew_feeder #(
  parameter int unsigned OPND_BWIDTH = 8,
  parameter int unsigned NUM_LANES   = 4
) (
  input  logic                               CLK,
  input  logic                               RSTn,
  input  logic                               ABORT,
  input  logic                               IN_valid,
  output logic                               IN_ready,
  input  logic                               IN_last,
  input  logic [NUM_LANES*OPND_BWIDTH-1:0]   IN_data,
  output logic [NUM_LANES*OPND_BWIDTH-1:0]   OPND_out,
  output logic [NUM_LANES-1:0]               OPND_is_valid_out,
  output logic                               COMPUTE,
  output logic                               BUSY,
  output logic                               DONE,
  output logic [15:0]                        BEAT_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Drain lasts NUM_LANES-1 cycles; the counter runs 0 .. NUM_LANES-2.
  localparam int unsigned CNT_W        = (NUM_LANES > 2) ? $clog2(NUM_LANES - 1) : 1;
  localparam int unsigned DRAIN_LAST_I = (NUM_LANES > 1) ? NUM_LANES - 2 : 0;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LAST_I);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             in_rdy;
  logic             accept;
  logic [15:0]      beat_cnt_q;

  // Ready is withheld during reset, abort and drain.
  assign in_rdy   = RSTn & ~ABORT & (state_q != DRAIN);
  assign accept   = IN_valid & in_rdy;
  assign IN_ready = in_rdy;

  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign COMPUTE  = BUSY | done_q;
  assign BEAT_CNT = beat_cnt_q;

  // State, drain counter and completion pulse registers.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; abort overrides everything and never produces DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (ABORT) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, FEED: begin
          if (accept) begin
            if (IN_last) begin
              if (NUM_LANES == 1) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = DRAIN;
                cnt_d   = '0;
              end
            end else begin
              state_d = FEED;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Beat counter: restarts at 1 on a job's first beat, saturates, holds otherwise.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      beat_cnt_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        beat_cnt_q <= 16'd1;
      end else if (beat_cnt_q != '1) begin
        beat_cnt_q <= beat_cnt_q + 16'd1;
      end
    end
  end

  // Per-lane delay lines of depth i+1; bubbles (valid 0, data 0) fill idle cycles.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int unsigned DEPTH = i + 1;

    logic [OPND_BWIDTH-1:0] data_q [DEPTH];
    logic                   vld_q  [DEPTH];

    // Shift one stage per cycle; reset and abort flush the whole line.
    always_ff @(posedge CLK) begin
      if (!RSTn || ABORT) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          data_q[k] <= '0;
          vld_q[k]  <= 1'b0;
        end
      end else begin
        data_q[0] <= accept ? IN_data[i*OPND_BWIDTH +: OPND_BWIDTH] : '0;
        vld_q[0]  <= accept;
        for (int unsigned k = 1; k < DEPTH; k++) begin
          data_q[k] <= data_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
      end
    end

    assign OPND_out[i*OPND_BWIDTH +: OPND_BWIDTH] = data_q[DEPTH-1];
    assign OPND_is_valid_out[i]                   = vld_q[DEPTH-1];
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Testbench for operand_skew_feeder (NUM_LANES=4, OPND_BWIDTH=8): directed
// vector table, hand-written corner sequences and random traffic against a
// cycle-history reference model.
module tb_operand_skew_feeder;

  localparam int NL = 4;
  localparam int W  = 8;

  logic          CLK;
  logic          RSTn;
  logic          ABORT;
  logic          IN_valid;
  logic          IN_ready;
  logic          IN_last;
  logic [31:0]   IN_data;
  logic [31:0]   OPND_out;
  logic [3:0]    OPND_is_valid_out;
  logic          COMPUTE;
  logic          BUSY;
  logic          DONE;
  logic [15:0]   BEAT_CNT;

  operand_skew_feeder #(.OPND_BWIDTH(W), .NUM_LANES(NL)) dut (
    .CLK              (CLK),
    .RSTn             (RSTn),
    .ABORT            (ABORT),
    .IN_valid         (IN_valid),
    .IN_ready         (IN_ready),
    .IN_last          (IN_last),
    .IN_data          (IN_data),
    .OPND_out         (OPND_out),
    .OPND_is_valid_out(OPND_is_valid_out),
    .COMPUTE          (COMPUTE),
    .BUSY             (BUSY),
    .DONE             (DONE),
    .BEAT_CNT         (BEAT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit mchk    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: history of what was accepted each cycle, plus job status.
  logic [31:0] mq_data[$];
  bit          mq_vld[$];
  bit          m_feed  = 0;
  int          m_drain = 0;
  bit          m_done  = 0;
  int          m_cnt   = 0;

  task automatic model_check();
    bit rdy, busy;
    logic [3:0]  vm;
    logic [31:0] od;
    int idx;
    rdy  = RSTn && !ABORT && (m_drain == 0);
    busy = m_feed || (m_drain > 0);
    vm = '0;
    od = '0;
    for (int i = 0; i < NL; i++) begin
      idx = mq_vld.size() - 1 - i;
      if (idx >= 0 && mq_vld[idx]) begin
        vm[i]          = 1'b1;
        od[i*W +: W]   = mq_data[idx][i*W +: W];
      end
    end
    chk("m_ready",   IN_ready,          rdy);
    chk("m_vmask",   OPND_is_valid_out, vm);
    chk("m_opnd",    OPND_out,          od);
    chk("m_done",    DONE,              m_done);
    chk("m_busy",    BUSY,              busy);
    chk("m_compute", COMPUTE,           busy || m_done);
    chk("m_beatcnt", BEAT_CNT,          m_cnt);
  endtask

  task automatic model_update();
    bit acc, nd;
    if (!RSTn || ABORT) begin
      m_feed  = 0;
      m_drain = 0;
      m_done  = 0;
      if (!RSTn) m_cnt = 0;
      mq_data.delete();
      mq_vld.delete();
    end else begin
      acc = IN_valid && (m_drain == 0);
      nd  = 0;
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) nd = 1;
      end
      if (acc) begin
        m_cnt = m_feed ? ((m_cnt < 65535) ? m_cnt + 1 : 65535) : 1;
        if (IN_last) begin
          m_feed  = 0;
          m_drain = NL - 1;
        end else begin
          m_feed = 1;
        end
      end
      mq_data.push_back(acc ? IN_data : 32'h0);
      mq_vld.push_back(acc);
      if (mq_vld.size() > 8) begin
        void'(mq_data.pop_front());
        void'(mq_vld.pop_front());
      end
      m_done = nd;
    end
  endtask

  task automatic drive(input bit r, input bit a, input bit v, input bit l, input logic [31:0] d);
    @(negedge CLK);
    RSTn = r; ABORT = a; IN_valid = v; IN_last = l; IN_data = d;
    #1;
    if (mchk) model_check();
  endtask

  task automatic adv();
    @(posedge CLK);
    model_update();
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 32'h0);
  endtask

  typedef struct {
    bit          rstn, abort, vld, last;
    logic [31:0] data;
    bit          e_rdy;
    logic [3:0]  e_vm;
    logic [31:0] e_out;
    bit          e_done, e_busy, e_comp;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit a, bit v, bit l, logic [31:0] d, bit rdy,
                              logic [3:0] vm, logic [31:0] o, bit dn, bit bz, bit cp,
                              logic [15:0] c);
    vec_t x;
    x.rstn = r; x.abort = a; x.vld = v; x.last = l; x.data = d;
    x.e_rdy = rdy; x.e_vm = vm; x.e_out = o; x.e_done = dn; x.e_busy = bz;
    x.e_comp = cp; x.e_cnt = c;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    int got, drn, dns;

    // Reset hold with valid offered, single-beat job, job with a bubble.
    tbl.push_back(mk(0,0,1,0,32'hAAAAAAAA, 0,4'h0,32'h00000000, 0,0,0,16'd0));
    tbl.push_back(mk(0,0,1,1,32'h55555555, 0,4'h0,32'h00000000, 0,0,0,16'd0));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 1,4'h0,32'h00000000, 0,0,0,16'd0));
    tbl.push_back(mk(1,0,1,1,32'h04030201, 1,4'h0,32'h00000000, 0,0,0,16'd0));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 0,4'h1,32'h00000001, 0,1,1,16'd1));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 0,4'h2,32'h00000200, 0,1,1,16'd1));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 0,4'h4,32'h00030000, 0,1,1,16'd1));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 1,4'h8,32'h04000000, 1,0,1,16'd1));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 1,4'h0,32'h00000000, 0,0,0,16'd1));
    tbl.push_back(mk(1,0,1,0,32'h11111111, 1,4'h0,32'h00000000, 0,0,0,16'd1));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 1,4'h1,32'h00000011, 0,1,1,16'd1));
    tbl.push_back(mk(1,0,1,1,32'h22222222, 1,4'h2,32'h00001100, 0,1,1,16'd1));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 0,4'h5,32'h00110022, 0,1,1,16'd2));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 0,4'hA,32'h11002200, 0,1,1,16'd2));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 0,4'h4,32'h00220000, 0,1,1,16'd2));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 1,4'h8,32'h22000000, 1,0,1,16'd2));
    tbl.push_back(mk(1,0,0,0,32'h00000000, 1,4'h0,32'h00000000, 0,0,0,16'd2));

    RSTn = 0; ABORT = 0; IN_valid = 1; IN_last = 0; IN_data = 32'h0;
    drive(0, 0, 1, 0, 32'hCAFEF00D);
    adv();
    mchk = 1;

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rstn, tbl[k].abort, tbl[k].vld, tbl[k].last, tbl[k].data);
      chk($sformatf("tbl%0d_ready",   k), IN_ready,          tbl[k].e_rdy);
      chk($sformatf("tbl%0d_vmask",   k), OPND_is_valid_out, tbl[k].e_vm);
      chk($sformatf("tbl%0d_opnd",    k), OPND_out,          tbl[k].e_out);
      chk($sformatf("tbl%0d_done",    k), DONE,              tbl[k].e_done);
      chk($sformatf("tbl%0d_busy",    k), BUSY,              tbl[k].e_busy);
      chk($sformatf("tbl%0d_compute", k), COMPUTE,           tbl[k].e_comp);
      chk($sformatf("tbl%0d_beatcnt", k), BEAT_CNT,          tbl[k].e_cnt);
      adv();
    end

    // Abort in the second drain cycle; new job accepted right after.
    drive(1, 0, 1, 1, 32'hA1B2C3D4); chk("ab_c0_ready", IN_ready, 1); adv();
    idle(); chk("ab_c1_busy", BUSY, 1); chk("ab_c1_ready", IN_ready, 0); adv();
    drive(1, 1, 1, 0, 32'hDEADBEEF); chk("ab_c2_ready", IN_ready, 0); adv();
    drive(1, 0, 1, 1, 32'h55667788);
    chk("ab_c3_vmask", OPND_is_valid_out, 4'h0); chk("ab_c3_busy", BUSY, 0);
    chk("ab_c3_done", DONE, 0); chk("ab_c3_ready", IN_ready, 1); chk("ab_c3_cnt", BEAT_CNT, 1);
    adv();
    idle(); chk("ab_c4_done", DONE, 0); chk("ab_c4_vmask", OPND_is_valid_out, 4'h1);
    chk("ab_c4_opnd", OPND_out, 32'h00000088); adv();
    idle(); chk("ab_c5_done", DONE, 0); adv();
    idle(); chk("ab_c6_done", DONE, 0); adv();
    idle(); chk("ab_c7_done", DONE, 1); chk("ab_c7_opnd", OPND_out, 32'h55000000);
    chk("ab_c7_cnt", BEAT_CNT, 1); adv();

    // Abort in FEED with a beat offered: beat refused, in-flight beat flushed.
    drive(1, 0, 1, 0, 32'h01020304); adv();
    drive(1, 1, 1, 1, 32'h0A0B0C0D); chk("abf_ready", IN_ready, 0); adv();
    idle(); chk("abf_busy", BUSY, 0); chk("abf_vmask", OPND_is_valid_out, 4'h0);
    chk("abf_cnt", BEAT_CNT, 1); chk("abf_done", DONE, 0); adv();

    // IN_last without IN_valid is ignored in FEED.
    drive(1, 0, 1, 0, 32'h10203040); adv();
    drive(1, 0, 0, 1, 32'hFFFFFFFF); chk("lnv_c1_ready", IN_ready, 1); chk("lnv_c1_busy", BUSY, 1); adv();
    idle(); chk("lnv_c2_busy", BUSY, 1); chk("lnv_c2_done", DONE, 0);
    chk("lnv_c2_ready", IN_ready, 1); chk("lnv_c2_cnt", BEAT_CNT, 1); adv();
    drive(1, 0, 1, 1, 32'h50607080); adv();
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      idle();
      if (DONE === 1'b1) begin
        got = 1;
        chk("lnv_cnt_at_done", BEAT_CNT, 2);
      end
      adv();
    end
    chk("lnv_done_seen", got, 1);

    // Beat counter saturation: 65537 beats then a last beat.
    for (int n = 0; n < 65537; n++) begin
      drive(1, 0, 1, 0, $urandom);
      adv();
    end
    drive(1, 0, 1, 1, $urandom); adv();
    drn = 0; dns = 0;
    for (int t = 0; t < 8; t++) begin
      idle();
      if (IN_ready === 1'b0) drn++;
      if (DONE === 1'b1) dns++;
      adv();
    end
    chk("sat_cnt", BEAT_CNT, 16'hFFFF);
    chk("sat_done_pulses", dns, 1);
    chk("sat_drain_cycles", drn, 3);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom % 200) != 0, ($urandom % 40) == 0, ($urandom % 3) != 0,
            ($urandom % 6) == 0, $urandom);
      adv();
    end
    for (int n = 0; n < 6; n++) begin
      idle();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

Interface
REQ-001 Parameter OPND_BWIDTH, 8, signed operand width (INT8) matching the PE operand width.
REQ-002 Parameter NUM_LANES, 4, number of PE rows/columns fed; legal range 1..32.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RSTn  input  1  reset; synchronous, active-low.
REQ-005 ABORT  input  1  synchronous job cancel.
REQ-006 IN_valid  input  1  upstream beat valid.
REQ-007 IN_ready  output  1  feeder can accept a beat.
REQ-008 IN_last  input  1  qualifies the final beat of a job; meaningful only with IN_valid.
REQ-009 IN_data  input  NUM_LANES*OPND_BWIDTH  one operand per lane; lane i = IN_data[i*OPND_BWIDTH +: OPND_BWIDTH].
REQ-010 OPND_out  output  NUM_LANES*OPND_BWIDTH  skewed operands to PE edge, same lane packing.
REQ-011 OPND_is_valid_out  output  NUM_LANES  per-lane operand valid to PE edge.
REQ-012 COMPUTE  output  1  drives PE COMPUTE while skewed data is in flight.
REQ-013 BUSY  output  1  state is not IDLE.
REQ-014 DONE  output  1  one-cycle pulse at job completion.
REQ-015 BEAT_CNT  output  16  beats accepted in current/last job.

Function
REQ-016 Beat accepted in a cycle iff IN_valid & IN_ready; IN_data/IN_last sampled only then.
REQ-017 Lane i SHALL be a delay line of depth i+1 registers: beat accepted in cycle c appears on lane i (data and valid=1) in cycle c+1+i.
REQ-018 Every cycle with no accepted beat SHALL shift a bubble (data 0, valid 0) into all lane delay lines; no stage ever holds stale valid data.
REQ-019 Bubble entries SHALL present OPND_out lane data 0 with valid 0.
REQ-020 FSM states: IDLE, FEED, DRAIN.
REQ-021 IDLE: IN_ready=1; accepted beat with IN_last=0 -> FEED; with IN_last=1 -> DRAIN (NUM_LANES>1) or IDLE with DONE next cycle (NUM_LANES=1).
REQ-022 FEED: IN_ready=1; accepted beat with IN_last=1 -> DRAIN (or IDLE+DONE if NUM_LANES=1); otherwise stay.
REQ-023 DRAIN: IN_ready=0; lasts exactly NUM_LANES-1 cycles counted by internal counter, then -> IDLE.
REQ-024 DONE SHALL be registered, high exactly in the first IDLE cycle after DRAIN, i.e. the cycle lane NUM_LANES-1 presents the last beat.
REQ-025 BUSY = (state != IDLE); COMPUTE = BUSY | DONE.
REQ-026 BEAT_CNT cleared on the accept edge of a job's first beat (IDLE accept) then loaded 1; increments per accepted beat; saturates at 0xFFFF; holds after DONE until next job.
REQ-027 IN_last with IN_valid=0 SHALL be ignored.
REQ-028 ABORT=1 (any state) SHALL at next edge force IDLE, clear all lane valids and data to 0, clear drain counter, suppress DONE; BEAT_CNT holds; beat offered in the ABORT cycle is not accepted (IN_ready=0 while ABORT=1).
REQ-029 Arithmetic: no data transformation; operands pass bit-exact.

Reset
REQ-030 RSTn=0 at an edge SHALL set state IDLE, all OPND_out and OPND_is_valid_out 0, COMPUTE/BUSY/DONE 0, BEAT_CNT 0, drain counter 0; IN_ready=0 while RSTn=0, 1 in first cycle after release.
REQ-031 Reset mid-FEED or mid-DRAIN SHALL discard in-flight beats with no DONE.

Verification (NUM_LANES=4, OPND_BWIDTH=8)
REQ-032 Reset: hold RSTn=0 2 cycles with IN_valid=1 -> all outputs 0, no accept; cycle after release IN_ready=1, BEAT_CNT=0.
REQ-033 Single-beat job: cycle 0 IN_data=0x04030201, IN_last=1 -> lane0=0x01 valid cycle 1, lane1=0x02 cycle 2, lane2=0x03 cycle 3, lane3=0x04 cycle 4; IN_ready=0 cycles 1-3; DONE=1 only cycle 4; BEAT_CNT=1; COMPUTE=1 cycles 1-4.
REQ-034 Job with bubble: beats 0x11111111 cycle 0, none cycle 1, 0x22222222 (last) cycle 2 -> lane3 valid 0x11 cycle 4, invalid cycle 5, 0x22 cycle 6; DONE cycle 6; BEAT_CNT=2.
REQ-035 ABORT in 2nd DRAIN cycle -> next cycle all valids 0, BUSY=0, no DONE ever; new job accepted immediately after.
REQ-036 IN_last=1 with IN_valid=0 in FEED -> state stays FEED, no DONE; BEAT_CNT unchanged.
REQ-037 Saturation: 65537 beats then last -> BEAT_CNT=0xFFFF, DONE once, 3 drain cycles.
